top_without_bc: RTL and testbench

- Top-level N-bit ripple-carry add/subtract block.
- The unit is a chain of N 1-bit full-adder cells. The result and carry-out are registered on the clock.
- pin_sel chooses add (0) or subtract (1).
- Top-level variant without boundary-scan cells: pins connect straight to the datapath and the output registers.

---
 rtl/top_without_bc.sv | 77 +++++++
 tb/tb_top_without_bc.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/top_without_bc.sv
// ============================================================================
// top_without_bc : N-bit ripple-carry add/subtract with registered outputs
// Optional macro ADDER_OVF_EN adds a registered signed-overflow output pin_ovf.
// Revision: 1.0
// ============================================================================
`default_nettype none

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module top_without_bc #(
    parameter int N = 16
) (
    input  logic         pin_clk,
    input  logic         pin_rst_n,
    input  logic [N-1:0] pin_a,
    input  logic [N-1:0] pin_b,
    input  logic         pin_cin,
    input  logic         pin_sel,
    output logic [N-1:0] pin_sum,
    output logic         pin_co
`ifdef ADDER_OVF_EN
    ,
    output logic         pin_ovf
`endif
);
    logic [N-1:0] w_b_eff;
    logic [N:0]   w_c;
    logic [N-1:0] w_s;

    // Subtract is A + ~B + ~cin, so both B and the carry-in are inverted by sel.
    assign w_b_eff = pin_b ^ {N{pin_sel}};
    assign w_c[0]  = pin_cin ^ pin_sel;

    generate
        for (genvar i = 0; i < N; i++) begin : g_cell
            full_adder_cell u_fa (
                .a  (pin_a[i]),
                .b  (w_b_eff[i]),
                .ci (w_c[i]),
                .s  (w_s[i]),
                .co (w_c[i+1])
            );
        end
    endgenerate

    always_ff @(posedge pin_clk) begin
        if (!pin_rst_n) begin
            pin_sum <= '0;
            pin_co  <= 1'b0;
        end else begin
            pin_sum <= w_s;
            pin_co  <= w_c[N];
        end
    end

`ifdef ADDER_OVF_EN
    always_ff @(posedge pin_clk) begin
        if (!pin_rst_n) begin
            pin_ovf <= 1'b0;
        end else begin
            pin_ovf <= w_c[N] ^ w_c[N-1];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_top_without_bc.sv
// Scoreboard bench for top_without_bc: driver pushes expected results, monitor pops and compares.
`default_nettype none

module tb_top_without_bc;
    localparam int N = 16;

    typedef struct {
        logic [N-1:0] sum;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sel = 1'b0;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf_obs;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

`ifdef ADDER_OVF_EN
    logic ovf;
    assign ovf_obs = ovf;
`else
    assign ovf_obs = 1'b0;
`endif

    top_without_bc #(.N(N)) dut (
        .pin_clk   (clk),
        .pin_rst_n (rst_n),
        .pin_a     (a),
        .pin_b     (b),
        .pin_cin   (cin),
        .pin_sel   (sel),
        .pin_sum   (sum),
        .pin_co    (co)
`ifdef ADDER_OVF_EN
        ,
        .pin_ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference model using plain integer arithmetic.
    function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                   input logic mcin, input logic msel, input logic mrst_n);
        exp_t e;
        longint ua, ub, uc, sa, sb, sres, r;
        ua = longint'(ma);
        ub = longint'(mb);
        uc = longint'(mcin);
        sa = (ua >= (64'sd1 << (N-1))) ? ua - (64'sd1 << N) : ua;
        sb = (ub >= (64'sd1 << (N-1))) ? ub - (64'sd1 << N) : ub;
        if (!mrst_n) begin
            e.sum = '0; e.co = 1'b0; e.ovf = 1'b0;
            return e;
        end
        if (!msel) begin
            r     = ua + ub + uc;
            e.co  = (r >= (64'sd1 << N));
            sres  = sa + sb + uc;
        end else begin
            r     = ua - ub - uc;
            e.co  = (ua >= ub + uc);
            sres  = sa - sb - uc;
        end
        e.sum = N'(r);
        e.ovf = (sres > ((64'sd1 << (N-1)) - 1)) || (sres < -(64'sd1 << (N-1)));
`ifndef ADDER_OVF_EN
        e.ovf = 1'b0;
`endif
        return e;
    endfunction

    task automatic drive(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                         input logic tcin, input logic tsel, input logic trst_n);
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sel = tsel; rst_n = trst_n;
        exp_q.push_back(model(ta, tb_, tcin, tsel, trst_n));
    endtask

    // Monitor: one result per edge, sampled 1 time unit after the edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (sum !== e.sum || co !== e.co || ovf_obs !== e.ovf) begin
                fails++;
                $display("FAIL result: got sum=%h co=%b ovf=%b, expected sum=%h co=%b ovf=%b",
                         sum, co, ovf_obs, e.sum, e.co, e.ovf);
            end
        end
    end

    initial begin
        // Reset held for two edges with all-ones operands.
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        // Add and full-ripple cases.
        drive(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1);
        drive(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        // Subtract, borrow, borrow-in, A-A.
        drive(16'h000F, 16'h0000, 1'b0, 1'b1, 1'b1);
        drive(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1);
        drive(16'h0010, 16'h0005, 1'b1, 1'b1, 1'b1);
        drive(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b1);
        drive(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);
        // Signed overflow cases.
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drive(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        drive(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        // Mid-stream single-cycle reset, then resume.
        drive(16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b1);
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        // Randomized back-to-back traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            drive(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 19) != 0));
        end
        repeat (3) @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

`default_nettype wire
